// File: rtl/control_unit_pkg.sv
// Shared definitions for the instruction sequencer: field widths, opcode
// encodings (ALU operations plus control opcodes) and opcode classifiers.
package control_unit_pkg;

  localparam int UNDEFINED     = 3;
  localparam int CNTR_WIDTH    = 8;
  localparam int ADDR_WIDTH    = 5;
  localparam int REG_BIT_CNT   = 3;
  localparam int DATA_WIDTH    = 8;
  localparam int COMBINED_DATA = ADDR_WIDTH + UNDEFINED + DATA_WIDTH;
  localparam int FLAG_COUNT    = 3;

  // Flag register bit positions
  localparam int FLAG_Z = 2;
  localparam int FLAG_L = 1;
  localparam int FLAG_G = 0;

  // ALU operations occupy the contiguous range NOP..LDr
  localparam logic [ADDR_WIDTH-1:0] OP_NOP  = 5'd0;
  localparam logic [ADDR_WIDTH-1:0] OP_XOR  = 5'd1;
  localparam logic [ADDR_WIDTH-1:0] OP_OR   = 5'd2;
  localparam logic [ADDR_WIDTH-1:0] OP_AND  = 5'd3;
  localparam logic [ADDR_WIDTH-1:0] OP_SUBR = 5'd4;
  localparam logic [ADDR_WIDTH-1:0] OP_ADDR = 5'd5;
  localparam logic [ADDR_WIDTH-1:0] OP_SR   = 5'd6;
  localparam logic [ADDR_WIDTH-1:0] OP_SL   = 5'd7;
  localparam logic [ADDR_WIDTH-1:0] OP_RR   = 5'd8;
  localparam logic [ADDR_WIDTH-1:0] OP_RL   = 5'd9;
  localparam logic [ADDR_WIDTH-1:0] OP_DEC  = 5'd10;
  localparam logic [ADDR_WIDTH-1:0] OP_INC  = 5'd11;
  localparam logic [ADDR_WIDTH-1:0] OP_NOT  = 5'd12;
  localparam logic [ADDR_WIDTH-1:0] OP_SUBI = 5'd13;
  localparam logic [ADDR_WIDTH-1:0] OP_ADDI = 5'd14;
  localparam logic [ADDR_WIDTH-1:0] OP_LDI  = 5'd15;
  localparam logic [ADDR_WIDTH-1:0] OP_LDR  = 5'd16;
  localparam logic [ADDR_WIDTH-1:0] OP_ST   = 5'd17;
  localparam logic [ADDR_WIDTH-1:0] OP_JMP  = 5'd18;
  localparam logic [ADDR_WIDTH-1:0] OP_JZ   = 5'd19;
  localparam logic [ADDR_WIDTH-1:0] OP_JLZ  = 5'd20;
  localparam logic [ADDR_WIDTH-1:0] OP_JGZ  = 5'd21;
  localparam logic [ADDR_WIDTH-1:0] OP_HLT  = 5'd22;

  function automatic logic is_alu_class(input logic [ADDR_WIDTH-1:0] op);
    return (op <= OP_LDR);
  endfunction

  function automatic logic is_imm_op(input logic [ADDR_WIDTH-1:0] op);
    return (op == OP_SUBI) || (op == OP_ADDI) || (op == OP_LDI);
  endfunction

endpackage

// File: rtl/control_unit_flag_reg.sv
// Latch for the ALU result flags; loads only when an ALU-class instruction
// executes so conditional jumps see the last arithmetic result.
module control_unit_flag_reg
  import control_unit_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [FLAG_COUNT-1:0] d,
  output logic [FLAG_COUNT-1:0] q
);

  logic [FLAG_COUNT-1:0] q_reg;

  generate
    for (genvar gi = 0; gi < FLAG_COUNT; gi++) begin : g_flag
      always_ff @(posedge clk) begin
        if (rst) begin
          q_reg[gi] <= 1'b0;
        end else if (load) begin
          q_reg[gi] <= d[gi];
        end
      end
    end
  endgenerate

  assign q = q_reg;

endmodule

// File: rtl/control_unit.sv
// Four-phase instruction sequencer (FETCH, DECODE, EXECUTE, WRITEBACK) that
// drives the ALU opcode/operand select and the accumulator/register strobes.
module control_unit
  import control_unit_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [COMBINED_DATA-1:0] instr_in,
  input  logic                     zero_f,
  input  logic                     ls_z_f,
  input  logic                     gr_z_f,
  output logic [CNTR_WIDTH-1:0]    pc_out,
  output logic [ADDR_WIDTH-1:0]    alu_op,
  output logic [DATA_WIDTH-1:0]    imm_out,
  output logic                     imm_sel,
  output logic [REG_BIT_CNT-1:0]   reg_rd_addr,
  output logic [REG_BIT_CNT-1:0]   reg_wr_addr,
  output logic                     acc_wr_en,
  output logic                     reg_wr_en,
  output logic                     halted
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_WRITEBACK = 3'd3,
    S_HALT      = 3'd4
  } state_t;

  state_t                   state_reg, state_next;
  logic [CNTR_WIDTH-1:0]    pc_reg, pc_next;
  logic [COMBINED_DATA-1:0] ir_reg;
  logic [COMBINED_DATA-1:0] word;
  logic [ADDR_WIDTH-1:0]    opcode;
  logic [DATA_WIDTH-1:0]    data;
  logic [CNTR_WIDTH-1:0]    target;
  logic [FLAG_COUNT-1:0]    flags_q;
  logic                     flag_load;
  logic                     unused_pad;

  // During DECODE the fields come straight from ROM data so the ALU sees the
  // new opcode in that same cycle; afterwards the instruction register holds them.
  assign word       = (state_reg == S_DECODE) ? instr_in : ir_reg;
  assign opcode     = word[COMBINED_DATA-1 -: ADDR_WIDTH];
  assign data       = word[DATA_WIDTH-1:0];
  assign target     = data[CNTR_WIDTH-1:0];
  assign unused_pad = ^word[DATA_WIDTH +: UNDEFINED];

  always_comb begin
    alu_op      = is_alu_class(opcode) ? opcode : OP_NOP;
    imm_out     = data;
    imm_sel     = is_imm_op(opcode);
    reg_rd_addr = data[REG_BIT_CNT-1:0];
    reg_wr_addr = data[REG_BIT_CNT-1:0];
  end

  control_unit_flag_reg u_flag_reg (
    .clk  (clk),
    .rst  (rst),
    .load (flag_load),
    .d    ({zero_f, ls_z_f, gr_z_f}),
    .q    (flags_q)
  );

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    acc_wr_en  = 1'b0;
    reg_wr_en  = 1'b0;
    flag_load  = 1'b0;
    // Nothing advances while disabled; reset also suppresses an in-flight write.
    if (en && !rst) begin
      case (state_reg)
        S_FETCH:   state_next = S_DECODE;
        S_DECODE:  state_next = S_EXECUTE;
        S_EXECUTE: begin
          state_next = S_WRITEBACK;
          flag_load  = is_alu_class(opcode);
        end
        S_WRITEBACK: begin
          state_next = S_FETCH;
          pc_next    = pc_reg + CNTR_WIDTH'(1);
          case (opcode)
            OP_ST:  reg_wr_en = 1'b1;
            OP_JMP: pc_next = target;
            OP_JZ:  if (flags_q[FLAG_Z]) pc_next = target;
            OP_JLZ: if (flags_q[FLAG_L]) pc_next = target;
            OP_JGZ: if (flags_q[FLAG_G]) pc_next = target;
            OP_HLT: begin
              state_next = S_HALT;
              pc_next    = pc_reg;
            end
            default: acc_wr_en = is_alu_class(opcode) && (opcode != OP_NOP);
          endcase
        end
        S_HALT:  state_next = S_HALT;
        default: state_next = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_FETCH;
      pc_reg    <= '0;
      ir_reg    <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      if (en && (state_reg == S_DECODE)) begin
        ir_reg <= instr_in;
      end
    end
  end

  assign pc_out = pc_reg;
  assign halted = (state_reg == S_HALT);

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench: a small datapath (ROM, accumulator, register file, ALU)
// around the sequencer, checked against an instruction-level reference model.
module tb_control_unit;
  import control_unit_pkg::*;

  logic                     clk = 1'b0;
  logic                     rst, en;
  logic [COMBINED_DATA-1:0] instr_in;
  logic                     zero_f, ls_z_f, gr_z_f;
  logic [CNTR_WIDTH-1:0]    pc_out;
  logic [ADDR_WIDTH-1:0]    alu_op;
  logic [DATA_WIDTH-1:0]    imm_out;
  logic                     imm_sel;
  logic [REG_BIT_CNT-1:0]   reg_rd_addr, reg_wr_addr;
  logic                     acc_wr_en, reg_wr_en, halted;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  control_unit dut (
    .clk(clk), .rst(rst), .en(en), .instr_in(instr_in),
    .zero_f(zero_f), .ls_z_f(ls_z_f), .gr_z_f(gr_z_f),
    .pc_out(pc_out), .alu_op(alu_op), .imm_out(imm_out), .imm_sel(imm_sel),
    .reg_rd_addr(reg_rd_addr), .reg_wr_addr(reg_wr_addr),
    .acc_wr_en(acc_wr_en), .reg_wr_en(reg_wr_en), .halted(halted)
  );

  // ALU behaviour shared by the harness datapath and the reference model
  function automatic logic [7:0] alu_fn(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      OP_XOR:          return a ^ b;
      OP_OR:           return a | b;
      OP_AND:          return a & b;
      OP_SUBR, OP_SUBI: return a - b;
      OP_ADDR, OP_ADDI: return a + b;
      OP_SR:           return a >> 1;
      OP_SL:           return a << 1;
      OP_RR:           return {a[0], a[7:1]};
      OP_RL:           return {a[6:0], a[7]};
      OP_DEC:          return a - 8'd1;
      OP_INC:          return a + 8'd1;
      OP_NOT:          return ~a;
      OP_LDI, OP_LDR:  return b;
      default:         return a;
    endcase
  endfunction

  function automatic logic [15:0] enc(input logic [4:0] op, input logic [7:0] d);
    return {op, 3'b000, d};
  endfunction

  // Harness datapath: synchronous ROM, accumulator, register file, ALU
  logic [15:0] rom [256];
  logic [7:0]  acc;
  logic [7:0]  regs [8];
  logic [7:0]  in2, alu_res;

  always @(posedge clk) instr_in <= rom[pc_out];

  always_comb begin
    in2     = imm_sel ? imm_out : regs[reg_rd_addr];
    alu_res = alu_fn(alu_op, acc, in2);
  end
  assign zero_f = (alu_res == 8'd0);
  assign ls_z_f = alu_res[7];
  assign gr_z_f = (alu_res != 8'd0) && !alu_res[7];

  always @(posedge clk) begin
    if (rst) begin
      acc <= 8'd0;
      for (int i = 0; i < 8; i++) regs[i] <= 8'd0;
    end else begin
      if (acc_wr_en) acc <= alu_res;
      if (reg_wr_en) regs[reg_wr_addr] <= acc;
    end
  end

  // Instruction-level reference model
  logic [7:0] m_pc, m_acc;
  logic [7:0] m_regs [8];
  logic       m_z, m_l, m_g, m_halted;

  task automatic model_reset();
    m_pc = 8'd0; m_acc = 8'd0; m_z = 0; m_l = 0; m_g = 0; m_halted = 0;
    for (int i = 0; i < 8; i++) m_regs[i] = 8'd0;
  endtask

  task automatic model_step(input logic [15:0] w);
    logic [4:0] op;
    logic [7:0] d, b, r;
    op = w[15:11];
    d  = w[7:0];
    if (op <= 5'd16) begin
      b = (op == OP_SUBI || op == OP_ADDI || op == OP_LDI) ? d : m_regs[d[2:0]];
      r = alu_fn(op, m_acc, b);
      m_z = (r == 8'd0); m_l = r[7]; m_g = (r != 8'd0) && !r[7];
      if (op != OP_NOP) m_acc = r;
      m_pc = m_pc + 8'd1;
    end else if (op == OP_ST) begin
      m_regs[d[2:0]] = m_acc;
      m_pc = m_pc + 8'd1;
    end else if (op == OP_JMP) m_pc = d;
    else if (op == OP_JZ)  m_pc = m_z ? d : m_pc + 8'd1;
    else if (op == OP_JLZ) m_pc = m_l ? d : m_pc + 8'd1;
    else if (op == OP_JGZ) m_pc = m_g ? d : m_pc + 8'd1;
    else if (op == OP_HLT) m_halted = 1;
    else m_pc = m_pc + 8'd1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic stall(input int k);
    en = 1'b0;
    repeat (k) begin
      #1;
      check("stall_strobes", 32'({acc_wr_en, reg_wr_en}), 32'd0);
      check("stall_pc", 32'(pc_out), 32'(m_pc));
      @(negedge clk);
    end
    en = 1'b1;
    #1;
  endtask

  task automatic maybe_stall(input bit allow);
    if (allow && ($urandom_range(0, 5) == 0)) stall($urandom_range(1, 3));
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'd0;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b1;
    @(negedge clk); @(negedge clk);
    model_reset();
    rst = 1'b0;
  endtask

  // Entered at a negedge during FETCH; leaves at the negedge after WRITEBACK.
  task automatic run_instr(input bit rnd_stall, input int wb_stall);
    logic [15:0] w;
    logic [4:0]  op;
    logic        exp_acc, exp_reg;
    w  = rom[m_pc];
    op = w[15:11];
    exp_acc = (op <= 5'd16) && (op != OP_NOP);
    exp_reg = (op == OP_ST);
    check("fetch_pc", 32'(pc_out), 32'(m_pc));
    check("fetch_halted", 32'(halted), 32'd0);
    maybe_stall(rnd_stall);
    @(negedge clk);
    check("dec_alu_op", 32'(alu_op), (op <= 5'd16) ? 32'(op) : 32'd0);
    check("dec_imm", 32'(imm_out), 32'(w[7:0]));
    check("dec_imm_sel", 32'(imm_sel), 32'(op == OP_SUBI || op == OP_ADDI || op == OP_LDI));
    maybe_stall(rnd_stall);
    @(negedge clk);
    check("exe_strobes", 32'({acc_wr_en, reg_wr_en}), 32'd0);
    maybe_stall(rnd_stall);
    @(negedge clk);
    if (wb_stall > 0) stall(wb_stall);
    else maybe_stall(rnd_stall);
    check("wb_acc_wr_en", 32'(acc_wr_en), 32'(exp_acc));
    check("wb_reg_wr_en", 32'(reg_wr_en), 32'(exp_reg));
    if (exp_reg) check("wb_reg_wr_addr", 32'(reg_wr_addr), 32'(w[2:0]));
    model_step(w);
    @(negedge clk);
    check("acc_value", 32'(acc), 32'(m_acc));
  endtask

  initial begin
    rst = 1'b1; en = 1'b1;
    clear_rom();

    // Reset state and a single LDi
    rom[0] = enc(OP_LDI, 8'h05);
    do_reset();
    #1;
    check("rst_pc", 32'(pc_out), 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'(OP_NOP));
    check("rst_imm", 32'(imm_out), 32'd0);
    check("rst_imm_sel", 32'(imm_sel), 32'd0);
    check("rst_addrs", 32'({reg_rd_addr, reg_wr_addr}), 32'd0);
    check("rst_strobes", 32'({acc_wr_en, reg_wr_en}), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    run_instr(0, 0);
    check("ldi_next_pc", 32'(pc_out), 32'd1);

    // LDi 1; DEC; JZ 7 -> taken
    clear_rom();
    rom[0] = enc(OP_LDI, 8'h01); rom[1] = enc(OP_DEC, 8'h00); rom[2] = enc(OP_JZ, 8'h07);
    do_reset();
    repeat (3) run_instr(0, 0);
    check("jz_taken_pc", 32'(pc_out), 32'h07);

    // LDi 3; JZ 7 not taken; JGZ 7 taken
    clear_rom();
    rom[0] = enc(OP_LDI, 8'h03); rom[1] = enc(OP_JZ, 8'h07); rom[2] = enc(OP_JGZ, 8'h07);
    do_reset();
    repeat (2) run_instr(0, 0);
    check("jz_not_taken_pc", 32'(pc_out), 32'h02);
    run_instr(0, 0);
    check("jgz_taken_pc", 32'(pc_out), 32'h07);

    // ST keeps flags: LDi 0; ST 5; JZ 0x20; LDr 5
    clear_rom();
    rom[0] = enc(OP_LDI, 8'h00); rom[1] = enc(OP_ST, 8'h05);
    rom[2] = enc(OP_JZ, 8'h20); rom[8'h20] = enc(OP_LDR, 8'h05);
    do_reset();
    repeat (3) run_instr(0, 0);
    check("st_flags_jz_pc", 32'(pc_out), 32'h20);
    run_instr(0, 0);

    // HLT at 0x0A holds, then reset restarts
    clear_rom();
    rom[0] = enc(OP_JMP, 8'h0A); rom[8'h0A] = enc(OP_HLT, 8'h00);
    do_reset();
    repeat (2) run_instr(0, 0);
    check("hlt_halted", 32'(halted), 32'd1);
    repeat (20) begin
      @(negedge clk);
      check("hlt_pc", 32'(pc_out), 32'h0A);
      check("hlt_strobes", 32'({acc_wr_en, reg_wr_en}), 32'd0);
    end
    do_reset();
    #1;
    check("hlt_rst_pc", 32'(pc_out), 32'd0);
    check("hlt_rst_halted", 32'(halted), 32'd0);

    // ADDr with WRITEBACK stalled for 3 cycles: exactly one accumulate
    clear_rom();
    rom[0] = enc(OP_LDI, 8'h07); rom[1] = enc(OP_ST, 8'h01);
    rom[2] = enc(OP_LDI, 8'h02); rom[3] = enc(OP_ADDR, 8'h01);
    do_reset();
    repeat (3) run_instr(0, 0);
    run_instr(0, 3);
    check("stall_addr_acc", 32'(acc), 32'h09);

    // PC wrap: NOP at 0xFF
    clear_rom();
    rom[0] = enc(OP_JMP, 8'hFF);
    do_reset();
    repeat (2) run_instr(0, 0);
    check("wrap_pc", 32'(pc_out), 32'h00);

    // Reset during WRITEBACK aborts the write
    clear_rom();
    rom[0] = enc(OP_LDI, 8'h33);
    do_reset();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_abort_strobe", 32'(acc_wr_en), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    check("rst_abort_pc", 32'(pc_out), 32'd0);

    // Randomized program with random stalls
    for (int i = 0; i < 256; i++) begin
      logic [4:0] op;
      op = 5'($urandom_range(0, 31));
      if (op == OP_HLT) op = 5'd31;
      rom[i] = enc(op, 8'($urandom_range(0, 255)));
    end
    do_reset();
    repeat (300) run_instr(1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Instruction sequencer for the wannabe-CPU datapath. It fetches instruction words from a synchronous program ROM, decodes them, and drives the ALU opcode, operand select and register-file/accumulator write strobes. It latches the ALU result flags and resolves conditional jumps from them. It is the initiator side of the ALU's `operation`/flag interface: it produces every opcode the ALU consumes and consumes every flag the ALU produces.

## Interface
- `UNDEFINED`, 3: unused padding bits between opcode and data field of an instruction word
- `CNTR_WIDTH`, 8: program counter width; must be ≤ `DATA_WIDTH`
- `ADDR_WIDTH`, 5: opcode field width; same value as the ALU's `operation` width
- `REG_BIT_CNT`, 3: register index width
- `DATA_WIDTH`, 8: datapath width
- `COMBINED_DATA`, `ADDR_WIDTH+UNDEFINED+DATA_WIDTH`: instruction word width
- `clk`  in  1  single clock; all state changes on the rising edge
- `rst`  in  1  reset, synchronous, active-high
- `en`  in  1  run enable; low freezes the sequencer
- `instr_in`  in  COMBINED_DATA  ROM data; valid one cycle after `pc_out` changes
- `zero_f`, `ls_z_f`, `gr_z_f`  in  1 each  ALU flags (combinational from the ALU)
- `pc_out`  out  CNTR_WIDTH  ROM address
- `alu_op`  out  ADDR_WIDTH  opcode to the ALU
- `imm_out`  out  DATA_WIDTH  immediate data field
- `imm_sel`  out  1  1 = ALU `in2` takes `imm_out`; 0 = takes the register file read data
- `reg_rd_addr`, `reg_wr_addr`  out  REG_BIT_CNT  register indices
- `acc_wr_en`  out  1  accumulator load strobe, one cycle
- `reg_wr_en`  out  1  register write strobe (accumulator to `reg_wr_addr`), one cycle
- `halted`  out  1  high once HLT has executed

## Operation
- Instruction fields:
  - opcode = `instr_in[COMBINED_DATA-1 -: ADDR_WIDTH]`
  - data = `instr_in[DATA_WIDTH-1:0]`
  - register index = data[REG_BIT_CNT-1:0]
  - jump target = data[CNTR_WIDTH-1:0]
- States: FETCH → DECODE → EXECUTE → WRITEBACK → FETCH. HALT is terminal until `rst`.
- FETCH: `pc_out` is stable; wait for ROM data.
- DECODE: register `instr_in` into the instruction register. Drive `alu_op`, `imm_out`, `imm_sel` and `reg_rd_addr` from it. These hold until the next DECODE.
- EXECUTE: ALU settles. For ALU-class opcodes, latch all three flags into the flag register.
  - ALU-class: NOP, XOR, OR, AND, SUBr, ADDr, SR, SL, RR, RL, DEC, INC, NOT, SUBi, ADDi, LDi, LDr.
  - `imm_sel` = 1 for SUBi, ADDi, LDi; 0 otherwise.
- WRITEBACK, by opcode:
  - ALU-class except NOP: pulse `acc_wr_en`.
  - ST: pulse `reg_wr_en` with `reg_wr_addr` = register index. `alu_op` = NOP. Flags unchanged.
  - JMP: PC ← target.
  - JZ / JLZ / JGZ: PC ← target if the latched zero / less / greater flag is 1; otherwise PC+1.
  - HLT: go to HALT, `halted` ← 1, PC unchanged.
  - Any other opcode: PC ← PC+1. Unknown opcodes behave as NOP: no writes, flags unchanged.
- PC increment wraps modulo 2^CNTR_WIDTH.
- Jumps use the flags latched by the most recent ALU-class instruction, never the live ALU flags.
- Opcode encodings for ST, JMP, JZ, JLZ, JGZ and HLT are added to the shared instruction include. Existing encodings are unchanged.

## Timing
- Reset values: state FETCH, `pc_out` 0, instruction register 0, flags 0, `alu_op` NOP, `imm_out` 0, `imm_sel` 0, both register addresses 0, `acc_wr_en` 0, `reg_wr_en` 0, `halted` 0.
- Every instruction takes exactly 4 enabled cycles. The first FETCH after reset presents address 0.
- `acc_wr_en` / `reg_wr_en` are high only during the WRITEBACK cycle, and only when `en` = 1.
- `en` = 0: state, PC, flags and outputs hold; write strobes are forced to 0. Resuming continues in the same state. A WRITEBACK stalled by `en` fires once `en` returns.
- `rst` in any state wins over `en` and HLT. An in-flight instruction is aborted with no write.
- Jump target equal to the current PC is legal: it loops at 4 cycles per iteration.
- PC at 2^CNTR_WIDTH−1 with a non-jump instruction → next FETCH at 0.

## Structure
- Opcode macros, including the new control opcodes, live in the shared instruction include used by the ALU.
- State encoding is a localparam set inside the block.
- One sub-module is natural: `flag_reg`, the 3-bit flag latch with load enable and synchronous reset.
- The top level instantiates `control_unit`, `alu`, the register file and the ROM.

## Test plan
- Reset, then `en` = 1, ROM[0] = LDi 0x05: `acc_wr_en` pulses in cycle 4; `alu_op` = LDi and `imm_out` = 0x05 from cycle 2; `imm_sel` = 1; `pc_out` = 1 in cycle 5.
- Program LDi 0x01; DEC; JZ 0x07, with ALU flags driven consistently: the zero flag is latched after DEC; `pc_out` jumps to 0x07; there is no write during JZ.
- Program LDi 0x03; JZ 0x07: not taken, `pc_out` = 2. Then JGZ 0x07: taken.
- ST with data 0x05: `reg_wr_en` pulses for one cycle with `reg_wr_addr` = 5; latched flags are unchanged.
- HLT at address 0x0A: `halted` = 1; `pc_out` stays 0x0A for 20 cycles; no strobes; `rst` returns to FETCH with PC 0.
- Drop `en` for 3 cycles during WRITEBACK of ADDr: no strobe while low; exactly one `acc_wr_en` pulse after resume. Separately, PC = 0xFF with NOP → next `pc_out` = 0x00.
